mag_cmp_bist: RTL
=================

// Module: mag_cmp_bist
// PURPOSE
//  Synthesizable self-checking stimulus engine for a WIDTH-bit magnitude comparator (gt/lt/eq outputs).
//  Drives every (a,b) operand pair into the comparator under test and samples its flags.
//  Checks the flags against a built-in golden compare, counts mismatches and captures the first failing pair.
//  Provides the on-chip initiator/checker end of the comparator interface; in hardware it takes over the role of a simulation bench.
// PARAMETERS
//  WIDTH   3  operand width of the comparator under test (1..8)
//  SETTLE  1  cycles operands are held before flags are sampled (>=1)
//  CNT_W   2*WIDTH+1  error counter width (derived localparam, not overridable)
// PORTS
//  clk      in   1        rising-edge clock
//  rst      in   1        synchronous, active-high reset
//  start    in   1        single-cycle request to run a full sweep
//  a_out    out  WIDTH    operand a to comparator under test (registered)
//  b_out    out  WIDTH    operand b to comparator under test (registered)
//  gt_in    in   1        comparator flag a>b
//  lt_in    in   1        comparator flag a<b
//  eq_in    in   1        comparator flag a==b
//  busy     out  1        sweep in progress
//  done     out  1        sweep finished; held until next accepted start or rst
//  pass     out  1        done && err_cnt==0
//  err_cnt  out  CNT_W    mismatch count, saturating at all-ones
//  fail_a   out  WIDTH    a of first mismatch (0 if none)
//  fail_b   out  WIDTH    b of first mismatch (0 if none)
// BEHAVIOUR
//  Reset: state=IDLE; a_out, b_out, err_cnt, fail_a, fail_b = 0; busy, done, pass = 0. Applies mid-sweep with no partial results kept.
//  FSM states: IDLE, WAIT, CHECK, DONE.
//   IDLE/DONE + start=1 -> WAIT; a_out=b_out=0; settle_cnt=SETTLE-1; err_cnt, fail_a, fail_b cleared; done=0; busy=1.
//   WAIT: settle_cnt decrements; when it reaches 0 -> CHECK.
//   CHECK: sample {gt_in,lt_in,eq_in}; expected is exactly one-hot {a>b, a<b, a==b} (unsigned).
//    Any mismatch, including zero or multiple flags asserted, increments err_cnt (saturating).
//    The first mismatch latches fail_a/fail_b.
//    If {a_out,b_out} is all-ones -> DONE (busy=0, done=1). Otherwise increment {a_out,b_out} (a major, b minor), reload settle_cnt -> WAIT.
//  Timing: operands change only on the CHECK->WAIT edge. Each vector takes SETTLE+1 cycles.
//   busy is high for exactly 2^(2*WIDTH)*(SETTLE+1) cycles.
//   Example, WIDTH=3, SETTLE=1: 128 cycles, then done rises.
//  start while busy: ignored. start in DONE: restarts the sweep, and done drops on the next edge.
//  pass is combinational from done and err_cnt. a_out/b_out keep their last value in DONE.
// CONFIGURATION
//  MAG_CMP_BIST_STOP_ON_FAIL_EN defined: the first mismatch in CHECK goes directly to DONE; err_cnt=1; fail_a/fail_b hold that pair; remaining vectors are skipped.
//  Not defined: the full sweep always runs, and every mismatch is counted.
// STRUCTURE
//  Package mag_cmp_pkg: FSM state localparams (2-bit encoding), function cmp_expect(a,b)->{gt,lt,eq}.
//  Sub-module mag_cmp_ref: combinational golden comparator instantiated for the expected flags.
//  Operand counter, settle counter and FSM stay in mag_cmp_bist.
// TESTING (WIDTH=3, SETTLE=1 unless stated)
//  Loopback to a correct mag_cmp_3b_beh, pulse start -> busy for 128 cycles, done=1, pass=1, err_cnt=0.
//  Faulty DUT with gt stuck at 0 -> err_cnt=28, fail_a=1, fail_b=0, pass=0.
//  Faulty DUT asserting eq and gt for a>b -> err_cnt=28; all-flags-low DUT -> err_cnt=64.
//  Assert rst at vector 20 -> next cycle all outputs 0, state IDLE; new start gives a full clean sweep.
//  start pulsed at cycle 10 of a sweep -> ignored, total busy still 128; start in DONE -> new sweep with err_cnt cleared.
//  With MAG_CMP_BIST_STOP_ON_FAIL_EN and gt stuck 0 -> done after vector index 8 (a=1,b=0), err_cnt=1; SETTLE=3 correct DUT -> busy 256 cycles.

Source files
------------

// File: rtl/mag_cmp_pkg.sv
// -----------------------------------------------------------------------------
// mag_cmp_pkg
// Shared definitions for the magnitude-comparator BIST engine.
//   state_t    : 2-bit FSM state encoding (IDLE, WAIT, CHECK, DONE)
//   MAX_W      : widest operand the golden compare function accepts
//   cmp_expect : golden unsigned compare, returns one-hot {gt, lt, eq}
// -----------------------------------------------------------------------------
package mag_cmp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int MAX_W = 8;

    // Operands are zero-extended to MAX_W by the caller, so the compare is unsigned.
    function automatic logic [2:0] cmp_expect(input logic [MAX_W-1:0] a,
                                              input logic [MAX_W-1:0] b);
        if (a > b)      return 3'b100;
        else if (a < b) return 3'b010;
        else            return 3'b001;
    endfunction

endpackage

// File: rtl/mag_cmp_ref.sv
// -----------------------------------------------------------------------------
// mag_cmp_ref
// Combinational golden magnitude comparator producing the expected flags.
// Ports:
//   a_i   [WIDTH-1:0]  operand a
//   b_i   [WIDTH-1:0]  operand b
//   exp_o [2:0]        expected {gt, lt, eq}, exactly one bit set
// -----------------------------------------------------------------------------
module mag_cmp_ref
    import mag_cmp_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [2:0]       exp_o
);

    assign exp_o = cmp_expect(MAX_W'(a_i), MAX_W'(b_i));

endmodule

// File: rtl/mag_cmp_bist.sv
// -----------------------------------------------------------------------------
// mag_cmp_bist
// Self-checking stimulus engine for a WIDTH-bit magnitude comparator.
// Sweeps every (a,b) pair (a major, b minor), holds each pair SETTLE cycles,
// samples the comparator flags and checks them against a golden compare.
// Counts mismatches (saturating) and captures the first failing pair.
//
// Optional feature (macro MAG_CMP_BIST_STOP_ON_FAIL_EN):
//   defined     : the first mismatch ends the sweep immediately (err_cnt = 1)
//   not defined : the full sweep always runs and every mismatch is counted
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous active-high reset
//   start    in   single-cycle sweep request (ignored while busy)
//   a_out    out  operand a to comparator under test (registered)
//   b_out    out  operand b to comparator under test (registered)
//   gt_in    in   comparator flag a>b
//   lt_in    in   comparator flag a<b
//   eq_in    in   comparator flag a==b
//   busy     out  sweep in progress
//   done     out  sweep finished, held until next accepted start or rst
//   pass     out  done with zero mismatches
//   err_cnt  out  mismatch count, saturating at all-ones
//   fail_a   out  a of first mismatch (0 if none)
//   fail_b   out  b of first mismatch (0 if none)
// -----------------------------------------------------------------------------
module mag_cmp_bist
    import mag_cmp_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [WIDTH-1:0]     a_out,
    output logic [WIDTH-1:0]     b_out,
    input  logic                 gt_in,
    input  logic                 lt_in,
    input  logic                 eq_in,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_cnt,
    output logic [WIDTH-1:0]     fail_a,
    output logic [WIDTH-1:0]     fail_b
);

    localparam int CNT_W = 2 * WIDTH + 1;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE - 1);

    state_t             state_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [SET_W-1:0]   settle_q;
    logic [CNT_W-1:0]   err_q;
    logic [WIDTH-1:0]   fail_a_q, fail_b_q;
    logic               busy_q, done_q;

    logic [2:0]         exp_flags;
    logic               mismatch;
    logic               last_vec;
    logic [2*WIDTH-1:0] ab_d;

    mag_cmp_ref #(.WIDTH(WIDTH)) u_ref (
        .a_i   (a_q),
        .b_i   (b_q),
        .exp_o (exp_flags)
    );

    // Zero or multiple flags asserted also differ from the one-hot expectation.
    assign mismatch = ({gt_in, lt_in, eq_in} != exp_flags);
    assign last_vec = &{a_q, b_q};
    // a and b form one counter so b wrapping carries into a.
    assign ab_d     = {a_q, b_q} + (2 * WIDTH)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            settle_q <= '0;
            err_q    <= '0;
            fail_a_q <= '0;
            fail_b_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q  <= S_WAIT;
                        a_q      <= '0;
                        b_q      <= '0;
                        settle_q <= SETTLE_INIT;
                        err_q    <= '0;
                        fail_a_q <= '0;
                        fail_b_q <= '0;
                        done_q   <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (settle_q == '0) state_q <= S_CHECK;
                    else                settle_q <= settle_q - SET_W'(1);
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_q != '1) err_q <= err_q + CNT_W'(1);
                        // Count never returns to zero, so zero marks the first mismatch.
                        if (err_q == '0) begin
                            fail_a_q <= a_q;
                            fail_b_q <= b_q;
                        end
                    end
`ifdef MAG_CMP_BIST_STOP_ON_FAIL_EN
                    if (mismatch || last_vec) begin
`else
                    if (last_vec) begin
`endif
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        {a_q, b_q} <= ab_d;
                        settle_q   <= SETTLE_INIT;
                        state_q    <= S_WAIT;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign a_out   = a_q;
    assign b_out   = b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = done_q && (err_q == '0);
    assign err_cnt = err_q;
    assign fail_a  = fail_a_q;
    assign fail_b  = fail_b_q;

endmodule
